// File: rtl/dvfs_transition_scheduler.sv
// dvfs_transition_scheduler
//
// Purpose:
//   Serialises per-domain DVFS transition requests onto one shared voltage
//   regulator interface and one shared PLL interface. Only one transition
//   runs at a time. Domains are served round-robin.
//   On a raise, the voltage moves first, the rail settles, then the frequency
//   moves. On a lower, the frequency moves first, then the voltage, then the
//   rail settles.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_i           per-domain transition request (level)
//   req_perf_i      per-domain target perf level, 3 bits per domain,
//                   domain d at [3*d +: 3]
//   ack_o / err_o   one-cycle per-domain pulse: completed / aborted on timeout
//   vreg_req_o, vreg_level_o, vreg_ack_i   regulator handshake
//   pll_req_o,  pll_level_o,  pll_ack_i    PLL / clock-mux handshake
//   cur_perf_o      last committed perf level
//   busy_o          scheduler is not idle
//   grant_id_o      domain being served (valid while busy_o)
//   timeout_cnt_o   saturating count of aborted transitions

module dvfs_transition_scheduler #(
    parameter int NUM_DOMAINS    = 8,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_DOMAINS-1:0]         req_i,
    input  logic [3*NUM_DOMAINS-1:0]       req_perf_i,
    output logic [NUM_DOMAINS-1:0]         ack_o,
    output logic [NUM_DOMAINS-1:0]         err_o,
    output logic                           vreg_req_o,
    output logic [2:0]                     vreg_level_o,
    input  logic                           vreg_ack_i,
    output logic                           pll_req_o,
    output logic [2:0]                     pll_level_o,
    input  logic                           pll_ack_i,
    output logic [2:0]                     cur_perf_o,
    output logic                           busy_o,
    output logic [$clog2(NUM_DOMAINS)-1:0] grant_id_o,
    output logic [15:0]                    timeout_cnt_o
);

    localparam int ID_W = $clog2(NUM_DOMAINS);
    localparam int MAXC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE,
        VOLT,
        SETTLE,
        FREQ,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   pointer;
    logic              mask_last;
    logic [2:0]        target;
    logic              raise;
    logic [CW-1:0]     count;

    logic [NUM_DOMAINS-1:0] eligible;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_sel;
    logic [2:0]             grant_perf;

    // Round-robin arbiter: search starts just after the last-served domain and
    // wraps. The last-served domain is masked for the one IDLE cycle that
    // follows DONE/ERR, so a requester that has not yet dropped its level
    // request is not re-granted on a stale request.
    always_comb begin
        int idx;
        idx         = 0;
        eligible    = req_i;
        grant_valid = 1'b0;
        grant_sel   = '0;
        if (mask_last) begin
            eligible[pointer] = 1'b0;
        end
        for (int k = 1; k <= NUM_DOMAINS; k++) begin
            idx = (int'(pointer) + k) % NUM_DOMAINS;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_sel   = ID_W'(idx);
            end
        end
        grant_perf = req_perf_i[3*int'(grant_sel) +: 3];
    end

    // Transition sequencer. Every output is registered. A pulse or request
    // that belongs to a state is therefore loaded on the transition into that
    // state, so it lines up with the state's own cycle.
    // A timeout can leave a transition half done. That is still safe,
    // because the frequency step is never taken ahead of the voltage it needs:
    //   - A raise that stops after VOLT leaves the voltage high and the
    //     frequency low.
    //   - A lower that stops after FREQ leaves the frequency low and the
    //     voltage high.
    // cur_perf_o is left untouched in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pointer       <= ID_W'(NUM_DOMAINS - 1);
            mask_last     <= 1'b0;
            target        <= '0;
            raise         <= 1'b0;
            count         <= '0;
            ack_o         <= '0;
            err_o         <= '0;
            vreg_req_o    <= 1'b0;
            vreg_level_o  <= '0;
            pll_req_o     <= 1'b0;
            pll_level_o   <= '0;
            cur_perf_o    <= '0;
            busy_o        <= 1'b0;
            grant_id_o    <= '0;
            timeout_cnt_o <= '0;
        end else begin
            ack_o <= '0;
            err_o <= '0;
            case (state)
                IDLE: begin
                    mask_last <= 1'b0;
                    if (grant_valid) begin
                        grant_id_o <= grant_sel;
                        target     <= grant_perf;
                        busy_o     <= 1'b1;
                        count      <= '0;
                        if (grant_perf == cur_perf_o) begin
                            state            <= DONE;
                            ack_o[grant_sel] <= 1'b1;
                            cur_perf_o       <= grant_perf;
                        end else if (grant_perf > cur_perf_o) begin
                            raise        <= 1'b1;
                            state        <= VOLT;
                            vreg_req_o   <= 1'b1;
                            vreg_level_o <= grant_perf;
                        end else begin
                            raise       <= 1'b0;
                            state       <= FREQ;
                            pll_req_o   <= 1'b1;
                            pll_level_o <= grant_perf;
                        end
                    end
                end

                // The ack is tested before the timer, so an ack that arrives
                // on the last allowed cycle still counts.
                VOLT: begin
                    if (vreg_ack_i) begin
                        vreg_req_o <= 1'b0;
                        count      <= '0;
                        state      <= SETTLE;
                    end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
                        vreg_req_o          <= 1'b0;
                        state               <= ERR;
                        err_o[grant_id_o]   <= 1'b1;
                        if (timeout_cnt_o != 16'hFFFF) begin
                            timeout_cnt_o <= timeout_cnt_o + 16'd1;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                SETTLE: begin
                    if (count == CW'(SETTLE_CYCLES - 1)) begin
                        count <= '0;
                        if (raise) begin
                            state       <= FREQ;
                            pll_req_o   <= 1'b1;
                            pll_level_o <= target;
                        end else begin
                            state             <= DONE;
                            ack_o[grant_id_o] <= 1'b1;
                            cur_perf_o        <= target;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                FREQ: begin
                    if (pll_ack_i) begin
                        pll_req_o <= 1'b0;
                        count     <= '0;
                        if (raise) begin
                            state             <= DONE;
                            ack_o[grant_id_o] <= 1'b1;
                            cur_perf_o        <= target;
                        end else begin
                            state        <= VOLT;
                            vreg_req_o   <= 1'b1;
                            vreg_level_o <= target;
                        end
                    end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
                        pll_req_o         <= 1'b0;
                        state             <= ERR;
                        err_o[grant_id_o] <= 1'b1;
                        if (timeout_cnt_o != 16'hFFFF) begin
                            timeout_cnt_o <= timeout_cnt_o + 16'd1;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                DONE, ERR: begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    pointer   <= grant_id_o;
                    mask_last <= 1'b1;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
